axi_memory_master: RTL and testbench

AXI_MEMORY_MASTER -- requirements
Module: axi_memory_master

---
 rtl/axi_memory_master.sv | 141 ++++++++++++++
 tb/tb_axi_memory_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_memory_master.sv
// axi_memory_master: single-outstanding AXI4 burst master driven by a simple command/stream interface
module axi_memory_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MASTER_ID  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [7:0]              i_cmd_len,
    input  logic                    i_wr_valid,
    output logic                    o_wr_ready,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_rd_valid,
    input  logic                    i_rd_ready,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_rd_last,
    output logic                    o_done,
    output logic [1:0]              o_done_resp,
    output logic                    o_done_len_err,
    output logic [ID_WIDTH-1:0]     o_awid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic [7:0]              o_awlen,
    output logic [2:0]              o_awsize,
    output logic [1:0]              o_awburst,
    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wlast,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    input  logic [ID_WIDTH-1:0]     i_bid,
    input  logic [1:0]              i_bresp,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    output logic [ID_WIDTH-1:0]     o_arid,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    output logic [7:0]              o_arlen,
    output logic [2:0]              o_arsize,
    output logic [1:0]              o_arburst,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    input  logic [ID_WIDTH-1:0]     i_rid,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]              i_rresp,
    input  logic                    i_rlast,
    input  logic                    i_rvalid,
    output logic                    o_rready
);
    localparam logic [2:0]          SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [ID_WIDTH-1:0] ID   = ID_WIDTH'(MASTER_ID);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

    state_t          r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]      r_len, r_cnt;
    logic [1:0]      r_resp;
    logic            r_len_err;
    logic            w_whs, w_rhs, w_unused;

    assign w_unused       = ^{i_bid, i_rid};
    assign w_whs          = o_wvalid & i_wready;
    assign w_rhs          = (r_state == R) & i_rvalid & i_rd_ready;
    assign o_cmd_ready    = r_state == IDLE;
    assign o_awid         = ID;
    assign o_arid         = ID;
    assign o_awaddr       = r_state == AW ? r_addr : '0;
    assign o_araddr       = r_state == AR ? r_addr : '0;
    assign o_awlen        = r_state == AW ? r_len : '0;
    assign o_arlen        = r_state == AR ? r_len : '0;
    assign o_awsize       = r_state == AW ? SIZE : '0;
    assign o_arsize       = r_state == AR ? SIZE : '0;
    assign o_awburst      = r_state == AW ? 2'b01 : 2'b00;
    assign o_arburst      = r_state == AR ? 2'b01 : 2'b00;
    assign o_awvalid      = r_state == AW;
    assign o_arvalid      = r_state == AR;
    assign o_wvalid       = (r_state == W) & i_wr_valid;
    assign o_wr_ready     = (r_state == W) & i_wready;
    assign o_wdata        = r_state == W ? i_wr_data : '0;
    assign o_wstrb        = r_state == W ? '1 : '0;
    assign o_wlast        = (r_state == W) & (r_cnt == r_len);
    assign o_bready       = r_state == B;
    assign o_rready       = (r_state == R) & i_rd_ready;
    assign o_rd_valid     = (r_state == R) & i_rvalid;
    assign o_rd_data      = r_state == R ? i_rdata : '0;
    assign o_rd_last      = (r_state == R) & i_rlast;
    assign o_done         = r_state == DONE;
    assign o_done_resp    = r_resp;
    assign o_done_len_err = r_len_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: one transaction at a time, exits on the last-beat handshakes
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_cmd_valid) w_next = i_cmd_write ? AW : AR;
            AW:      if (i_awready) w_next = W;
            W:       if (w_whs && o_wlast) w_next = B;
            B:       if (i_bvalid) w_next = DONE;
            AR:      if (i_arready) w_next = R;
            R:       if (w_rhs && i_rlast) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Command capture, beat counting and response/length-error accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_resp    <= '0;
            r_len_err <= 1'b0;
        end else begin
            if (r_state == IDLE && i_cmd_valid) begin
                r_addr    <= i_cmd_addr;
                r_len     <= i_cmd_len;
                r_resp    <= '0;
                r_len_err <= 1'b0;
            end
            if ((r_state == AW && i_awready) || (r_state == AR && i_arready)) r_cnt <= '0;
            if (w_whs || w_rhs) r_cnt <= r_cnt + 8'd1;
            if (r_state == B && i_bvalid) r_resp <= i_bresp;
            if (w_rhs) begin
                r_resp    <= i_rresp > r_resp ? i_rresp : r_resp;
                r_len_err <= r_len_err | (i_rlast ? r_cnt != r_len : r_cnt == r_len);
            end
        end
    end
endmodule

// File: tb/tb_axi_memory_master.sv
// tb_axi_memory_master: directed scenario tests for axi_memory_master
module tb_axi_memory_master;
    logic        clk = 1'b0, rst = 1'b1;
    logic        i_cmd_valid = 0, i_cmd_write = 0;
    logic [31:0] i_cmd_addr = 0;
    logic [7:0]  i_cmd_len = 0;
    logic        i_wr_valid = 0, i_rd_ready = 0;
    logic [31:0] i_wr_data = 0, i_rdata = 0;
    logic        i_awready = 0, i_wready = 0, i_bvalid = 0, i_arready = 0, i_rlast = 0, i_rvalid = 0;
    logic [3:0]  i_bid = 0, i_rid = 0;
    logic [1:0]  i_bresp = 0, i_rresp = 0;
    logic        o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_last, o_done, o_done_len_err;
    logic [31:0] o_rd_data, o_awaddr, o_wdata, o_araddr;
    logic [1:0]  o_done_resp, o_awburst, o_arburst;
    logic [3:0]  o_awid, o_arid, o_wstrb;
    logic [7:0]  o_awlen, o_arlen;
    logic [2:0]  o_awsize, o_arsize;
    logic        o_awvalid, o_wlast, o_wvalid, o_bready, o_arvalid, o_rready;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    axi_memory_master dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
        .o_done(o_done), .o_done_resp(o_done_resp), .o_done_len_err(o_done_len_err),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
        .o_rready(o_rready)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Presents one command for a single cycle; caller is positioned before a rising edge in IDLE
    task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [7:0] l);
        i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = a; i_cmd_len = l;
        @(negedge clk);
        i_cmd_valid = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk); #1;
        checks++;
        if ({o_cmd_ready, o_awvalid, o_wvalid, o_wr_ready, o_bready, o_arvalid, o_rready, o_rd_valid, o_done} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 100000000", {o_cmd_ready, o_awvalid, o_wvalid, o_wr_ready, o_bready, o_arvalid, o_rready, o_rd_valid, o_done});
        end
        checks++;
        if ({o_awaddr, o_araddr, o_awlen, o_arlen, o_awsize, o_arsize, o_wstrb, o_done_resp, o_done_len_err, o_wlast, o_rd_last, o_wdata, o_rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_data got nonzero awaddr=%h awlen=%h resp=%b exp all zero", o_awaddr, o_awlen, o_done_resp);
        end
    endtask

    task automatic test_write_basic;
        logic [31:0] d;
        i_awready = 1; i_wready = 1;
        checks++;
        if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready got %b exp 1", o_cmd_ready); end
        issue_cmd(1, 32'h100, 8'd3);
        #1;
        checks++;
        if ({o_awvalid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awid, o_cmd_ready} !== {1'b1, 32'h100, 8'd3, 3'd2, 2'b01, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL wr_aw got v=%b a=%h l=%0d s=%0d b=%b exp v=1 a=100 l=3 s=2 b=01", o_awvalid, o_awaddr, o_awlen, o_awsize, o_awburst);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            d = 32'hA000_0000 + 32'(k);
            i_wr_valid = 1; i_wr_data = d; #1;
            checks++;
            if ({o_wvalid, o_wdata, o_wlast, o_wstrb, o_awvalid} !== {1'b1, d, k == 3, 4'hF, 1'b0}) begin
                errors++;
                $display("FAIL wr_beat%0d got v=%b d=%h last=%b strb=%h exp v=1 d=%h last=%b strb=f", k, o_wvalid, o_wdata, o_wlast, o_wstrb, d, k == 3);
            end
            @(negedge clk);
        end
        i_wr_valid = 0; #1;
        checks++;
        if ({o_bready, o_wvalid, o_wr_ready} !== 3'b100) begin errors++; $display("FAIL wr_bstate got %b exp 100", {o_bready, o_wvalid, o_wr_ready}); end
        i_bvalid = 1; i_bresp = 2'b00;
        @(negedge clk);
        i_bvalid = 0; #1;
        checks++;
        if ({o_done, o_done_resp, o_done_len_err, o_bready} !== 5'b1_00_0_0) begin
            errors++;
            $display("FAIL wr_done got %b exp 10000", {o_done, o_done_resp, o_done_len_err, o_bready});
        end
        @(negedge clk); #1;
        checks++;
        if ({o_done, o_cmd_ready} !== 2'b01) begin errors++; $display("FAIL wr_idle got %b exp 01", {o_done, o_cmd_ready}); end
    endtask

    task automatic test_read_delayed;
        i_arready = 0; i_rd_ready = 1;
        issue_cmd(0, 32'h2000, 8'd0);
        for (int c = 0; c < 6; c++) begin
            if (c == 5) i_arready = 1;
            #1;
            checks++;
            if ({o_arvalid, o_araddr, o_arlen, o_arburst, o_arsize} !== {1'b1, 32'h2000, 8'd0, 2'b01, 3'd2}) begin
                errors++;
                $display("FAIL rd_ar_hold%0d got v=%b a=%h l=%0d exp v=1 a=2000 l=0", c, o_arvalid, o_araddr, o_arlen);
            end
            @(negedge clk);
        end
        i_arready = 0;
        i_rvalid = 1; i_rdata = 32'hDEAD_BEEF; i_rlast = 1; i_rresp = 2'b00; #1;
        checks++;
        if ({o_arvalid, o_rd_valid, o_rd_data, o_rd_last, o_rready} !== {1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rd_beat got arv=%b v=%b d=%h last=%b rr=%b exp 0 1 deadbeef 1 1", o_arvalid, o_rd_valid, o_rd_data, o_rd_last, o_rready);
        end
        @(negedge clk);
        i_rvalid = 0; i_rlast = 0; #1;
        checks++;
        if ({o_done, o_done_resp, o_done_len_err} !== 4'b1_00_0) begin
            errors++;
            $display("FAIL rd_single_done got %b exp 1000", {o_done, o_done_resp, o_done_len_err});
        end
        @(negedge clk);
    endtask

    task automatic test_read_resp;
        logic [1:0] seq [3] = '{2'b00, 2'b10, 2'b00};
        i_arready = 1;
        issue_cmd(0, 32'h3000, 8'd2);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            i_rvalid = 1; i_rresp = seq[k]; i_rlast = (k == 2); i_rdata = 32'h5500 + 32'(k); #1;
            checks++;
            if ({o_rd_data, o_rd_last, o_done} !== {32'h5500 + 32'(k), k == 2, 1'b0}) begin
                errors++;
                $display("FAIL rresp_beat%0d got d=%h last=%b done=%b exp d=%h last=%b done=0", k, o_rd_data, o_rd_last, o_done, 32'h5500 + 32'(k), k == 2);
            end
            @(negedge clk);
        end
        i_rvalid = 0; i_rlast = 0; i_rresp = 0; #1;
        checks++;
        if ({o_done, o_done_resp, o_done_len_err} !== 4'b1_10_0) begin
            errors++;
            $display("FAIL rresp_done got %b exp 1100", {o_done, o_done_resp, o_done_len_err});
        end
        @(negedge clk);
    endtask

    task automatic test_read_short;
        i_arready = 1;
        issue_cmd(0, 32'h4000, 8'd3);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            i_rvalid = 1; i_rlast = (k == 1); i_rdata = 32'(k); #1;
            @(negedge clk);
        end
        i_rvalid = 0; i_rlast = 0; #1;
        checks++;
        if ({o_done, o_done_resp, o_done_len_err, o_rready} !== 5'b1_00_1_0) begin
            errors++;
            $display("FAIL short_done got %b exp 10010", {o_done, o_done_resp, o_done_len_err, o_rready});
        end
        @(negedge clk);
    endtask

    task automatic test_read_long;
        i_arready = 1;
        issue_cmd(0, 32'h4100, 8'd1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            i_rvalid = 1; i_rlast = (k == 3); i_rresp = (k == 1) ? 2'b01 : 2'b00; #1;
            if (k == 2) begin
                checks++;
                if ({o_rready, o_rd_valid, o_done} !== 3'b110) begin
                    errors++;
                    $display("FAIL long_extra_beat got %b exp 110", {o_rready, o_rd_valid, o_done});
                end
            end
            @(negedge clk);
        end
        i_rvalid = 0; i_rlast = 0; i_rresp = 0; #1;
        checks++;
        if ({o_done, o_done_resp, o_done_len_err} !== 4'b1_01_1) begin
            errors++;
            $display("FAIL long_done got %b exp 1011", {o_done, o_done_resp, o_done_len_err});
        end
        @(negedge clk);
    endtask

    task automatic test_write_random;
        int   beats = 0;
        logic left = 0;
        logic [31:0] d;
        i_awready = 1;
        issue_cmd(1, 32'h8000, 8'd7);
        @(negedge clk);
        for (int c = 0; c < 300 && !left; c++) begin
            d = 32'hB000_0000 + 32'(beats);
            i_wr_valid = (c % 2 == 0); i_wready = 1'($urandom_range(0, 1)); i_wr_data = d; #1;
            checks++;
            if ({o_wvalid, o_wr_ready} !== {i_wr_valid, i_wready}) begin
                errors++;
                $display("FAIL rnd_passthru got %b exp %b", {o_wvalid, o_wr_ready}, {i_wr_valid, i_wready});
            end
            if (i_wr_valid && i_wready) begin
                checks++;
                if ({o_wdata, o_wlast} !== {d, beats == 7}) begin
                    errors++;
                    $display("FAIL rnd_beat%0d got d=%h last=%b exp d=%h last=%b", beats, o_wdata, o_wlast, d, beats == 7);
                end
                left = o_wlast;
                beats++;
            end
            @(negedge clk);
        end
        i_wr_valid = 0; i_wready = 0;
        checks++;
        if (beats !== 8 || !left) begin errors++; $display("FAIL rnd_count got %0d beats exp 8", beats); end
        #1;
        checks++;
        if (o_bready !== 1'b1) begin errors++; $display("FAIL rnd_bready got %b exp 1", o_bready); end
        i_bvalid = 1; i_bresp = 2'b11;
        @(negedge clk);
        i_bvalid = 0; i_bresp = 0; #1;
        checks++;
        if ({o_done, o_done_resp, o_done_len_err} !== 4'b1_11_0) begin
            errors++;
            $display("FAIL rnd_done got %b exp 1110", {o_done, o_done_resp, o_done_len_err});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        i_awready = 1; i_wready = 1;
        issue_cmd(1, 32'h9000, 8'd3);
        @(negedge clk);
        i_wr_valid = 1; i_wr_data = 32'h1;
        @(negedge clk);
        i_wr_data = 32'h2; #1;
        checks++;
        if (o_wvalid !== 1'b1) begin errors++; $display("FAIL rstmid_beat2 got wvalid=%b exp 1", o_wvalid); end
        rst = 1;
        @(negedge clk); #1;
        checks++;
        if ({o_wvalid, o_wr_ready, o_awvalid, o_done} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_drop got %b exp 0000", {o_wvalid, o_wr_ready, o_awvalid, o_done});
        end
        rst = 0; i_wr_valid = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (o_done) dones++;
        end
        checks++;
        if (dones !== 0 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle got dones=%0d cmd_ready=%b exp 0 1", dones, o_cmd_ready);
        end
        i_arready = 0;
        issue_cmd(0, 32'h40, 8'd0);
        #1;
        checks++;
        if ({o_arvalid, o_araddr, o_cmd_ready} !== {1'b1, 32'h40, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_newcmd got v=%b a=%h rdy=%b exp 1 40 0", o_arvalid, o_araddr, o_cmd_ready);
        end
        i_arready = 1;
        @(negedge clk);
        i_arready = 0; i_rvalid = 1; i_rlast = 1;
        @(negedge clk);
        i_rvalid = 0; i_rlast = 0; #1;
        checks++;
        if ({o_done, o_done_len_err} !== 2'b10) begin errors++; $display("FAIL rstmid_done got %b exp 10", {o_done, o_done_len_err}); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_write_basic;
        test_read_delayed;
        test_read_resp;
        test_read_short;
        test_read_long;
        test_write_random;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
